instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Front end of the 64-bit LEGv8 core: owns the program counter and reads instruction words from instruction memory over a request/ack handshake.
- Presents each word as instr to the control decoder and consumes the decoder's br_taken/uncond_br to choose the next PC.
- Produces the instr bus that the control decoder consumes.

Parameters:
- PC_W, 64, program counter width in bits.
- RESET_PC, 64'h0, PC loaded on reset; bits [1:0] must be 0.

Ports:
- clk  input  1  rising-edge clock.
- reset_n  input  1  synchronous active-low reset.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  PC_W  byte address of the request; equals pc.
- imem_rdata  input  32  instruction word; valid when imem_ack=1.
- imem_ack  input  1  read complete.
- instr  output  32  held instruction word to the decoder.
- instr_valid  output  1  instr is valid this cycle.
- instr_ready  input  1  downstream accepts instr this cycle.
- br_taken  input  1  decoder branch-taken for the current instr.
- uncond_br  input  1  1 selects the 26-bit offset, 0 selects the 19-bit offset.
- pc  output  PC_W  address of the current or pending instruction.

Behaviour:
- Reset values when reset_n=0 at a clock edge:
  - state=IDLE, pc=RESET_PC, instr=0, instr_valid=0, imem_req=0.
- FSM states: IDLE, FETCH, ISSUE.
- IDLE:
  - imem_req=0; go to FETCH next cycle.
  - Exists so that memory sees a clean request edge after reset.
- FETCH:
  - imem_req=1, imem_addr=pc.
  - On imem_ack=1: capture instr<=imem_rdata, go to ISSUE.
  - Ack may come in the first FETCH cycle, so minimum fetch latency is 1 cycle. Any number of wait cycles is allowed; imem_addr stays stable until ack.
- ISSUE:
  - instr_valid=1, imem_req=0; instr and pc held stable.
  - br_taken and uncond_br are sampled only when instr_valid && instr_ready. On that handshake, pc<=next_pc and go to FETCH.
  - While instr_ready=0, stay in ISSUE with all outputs unchanged.
- Next-PC rule, using instr captured in ISSUE:
  - br_taken=0: next_pc = pc + 4.
  - br_taken=1, uncond_br=1: next_pc = pc + (sext(instr[25:0]) << 2).
  - br_taken=1, uncond_br=0: next_pc = pc + (sext(instr[23:5]) << 2).
  - Sign-extend to PC_W. Arithmetic is modulo 2^PC_W; wrap-around is silent.
  - pc[1:0] is always 0.
- Throughput: one instruction per 2 cycles with 1-cycle ack and instr_ready held high (FETCH, ISSUE).
- imem_ack outside FETCH is ignored and instr is not modified.
- br_taken and uncond_br are ignored outside the ISSUE handshake.
- Reset mid-operation: synchronous reset in any state aborts it. Any pending fetch is dropped, and a late ack after reset is ignored because it arrives while the FSM is in IDLE.
- No other state transitions exist. Unreachable encodings return to IDLE.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- When defined, two extra output ports are added:
  - fetch_cnt [31:0]: increments on each ISSUE handshake.
  - taken_cnt [31:0]: increments on each ISSUE handshake with br_taken=1.
- Both counters reset to 0, wrap at 2^32 and are not saturating.
- When undefined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset then run, ack 1 cycle, instr_ready=1, no branches:
  - imem_addr sequence 0x0, 0x4, 0x8.
  - instr_valid high every 2nd cycle.
  - instr equals imem_rdata.
- Unconditional branch at pc=0x10 with instr[25:0]=26'h3FFFFFE, br_taken=1, uncond_br=1 -> next imem_addr=0x8.
- Conditional branch at pc=0x20 with instr[23:5]=19'h00004, br_taken=1, uncond_br=0 -> next imem_addr=0x30. Same instr with br_taken=0 -> next imem_addr=0x24.
- Stalls:
  - ack delayed 3 cycles -> imem_addr stable for 4 cycles.
  - instr_ready low for 5 cycles -> instr, pc and instr_valid unchanged; no new imem_req.
- Wrap: pc=0xFFFF_FFFF_FFFF_FFFC, br_taken=0 -> next imem_addr=0x0.
- Reset during FETCH with ack arriving the following cycle:
  - ack ignored; instr=0; pc=RESET_PC.
  - Fetch restarts after IDLE.
  - With FETCH_PERF_CNT_EN defined, both counters read 0.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// LEGv8 fetch front end: owns the PC, fetches words over req/ack, holds each for the decoder.
// Optional FETCH_PERF_CNT_EN adds fetch_cnt/taken_cnt handshake counters.
module instr_fetch_unit #(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset_n,
  output logic            imem_req,
  output logic [PC_W-1:0] imem_addr,
  input  logic [31:0]     imem_rdata,
  input  logic            imem_ack,
  output logic [31:0]     instr,
  output logic            instr_valid,
  input  logic            instr_ready,
  input  logic            br_taken,
  input  logic            uncond_br,
`ifdef FETCH_PERF_CNT_EN
  output logic [31:0]     fetch_cnt,
  output logic [31:0]     taken_cnt,
`endif
  output logic [PC_W-1:0] pc
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] FETCH = 2'd1;
  localparam logic [1:0] ISSUE = 2'd2;

  logic [1:0]      r_state;
  logic [PC_W-1:0] r_pc;
  logic [31:0]     r_instr;

  logic            w_issue_hs;
  logic [PC_W-1:0] w_off26;
  logic [PC_W-1:0] w_off19;
  logic [PC_W-1:0] w_br_off;
  logic [PC_W-1:0] w_next_pc;

  assign w_issue_hs = (r_state == ISSUE) && instr_ready;

  // Branch offsets are word counts; the two low zero bits keep pc word aligned.
  assign w_off26  = {{(PC_W-28){r_instr[25]}}, r_instr[25:0], 2'b00};
  assign w_off19  = {{(PC_W-21){r_instr[23]}}, r_instr[23:5], 2'b00};
  assign w_br_off = uncond_br ? w_off26 : w_off19;

  always_comb begin
    w_next_pc = r_pc + PC_W'(4);
    if (br_taken) begin
      w_next_pc = r_pc + w_br_off;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pc    <= RESET_PC;
      r_instr <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          r_state <= FETCH;
        end
        FETCH: begin
          if (imem_ack) begin
            r_instr <= imem_rdata;
            r_state <= ISSUE;
          end
        end
        ISSUE: begin
          if (instr_ready) begin
            r_pc    <= w_next_pc;
            r_state <= FETCH;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign imem_req    = (r_state == FETCH);
  assign imem_addr   = r_pc;
  assign instr       = r_instr;
  assign instr_valid = (r_state == ISSUE);
  assign pc          = r_pc;

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] r_fetch_cnt;
  logic [31:0] r_taken_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_fetch_cnt <= '0;
      r_taken_cnt <= '0;
    end else if (w_issue_hs) begin
      r_fetch_cnt <= r_fetch_cnt + 32'd1;
      if (br_taken) begin
        r_taken_cnt <= r_taken_cnt + 32'd1;
      end
    end
  end

  assign fetch_cnt = r_fetch_cnt;
  assign taken_cnt = r_taken_cnt;
`else
  logic w_unused_hs;
  assign w_unused_hs = w_issue_hs;
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: driver issues fetch/issue transactions, a negedge
// monitor pops the scoreboard on each decoder handshake.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        imem_req;
  logic [63:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic [31:0] instr;
  logic        instr_valid;
  logic        instr_ready;
  logic        br_taken;
  logic        uncond_br;
  logic [63:0] pc;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] taken_cnt;
`endif

  always #5 clk = ~clk;

  instr_fetch_unit dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .imem_ack   (imem_ack),
    .instr      (instr),
    .instr_valid(instr_valid),
    .instr_ready(instr_ready),
    .br_taken   (br_taken),
    .uncond_br  (uncond_br),
`ifdef FETCH_PERF_CNT_EN
    .fetch_cnt  (fetch_cnt),
    .taken_cnt  (taken_cnt),
`endif
    .pc         (pc)
  );

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%h expected 0x%h", name, act, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Decoder-side handshake monitor.
  always @(negedge clk) begin
    if (reset_n === 1'b1 && instr_valid === 1'b1 && instr_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("sb_unexpected_issue", 64'd1, 64'd0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("sb_pc", pc, mon_e.pc);
        chk("sb_instr", 64'(instr), 64'(mon_e.instr));
      end
    end
  end

  task automatic fetch_issue(input logic [31:0] word, input int ack_dly, input int rdy_dly,
                             input logic bt, input logic ub, input logic [63:0] exp_pc);
    int guard;
    guard = 0;
    while (imem_req !== 1'b1 && guard < 20) begin
      step();
      guard++;
    end
    if (imem_req !== 1'b1) begin
      chk("req_timeout", 64'd0, 64'd1);
      return;
    end
    for (int i = 0; i < ack_dly; i++) begin
      chk("wait_addr", imem_addr, exp_pc);
      chk("wait_req", 64'(imem_req), 64'd1);
      step();
    end
    chk("fetch_addr", imem_addr, exp_pc);
    chk("fetch_valid_low", 64'(instr_valid), 64'd0);
    imem_ack    = 1'b1;
    imem_rdata  = word;
    br_taken    = bt;
    uncond_br   = ub;
    instr_ready = (rdy_dly == 0);
    sb_q.push_back('{pc: exp_pc, instr: word});
    step();
    imem_ack   = 1'b0;
    imem_rdata = 32'h0BAD_F00D;
    chk("issue_valid", 64'(instr_valid), 64'd1);
    chk("issue_req", 64'(imem_req), 64'd0);
    for (int i = 0; i < rdy_dly; i++) begin
      // Stray ack while stalled in ISSUE must not disturb the held word.
      imem_ack   = 1'b1;
      imem_rdata = 32'hFFFF_0000 | 32'(i);
      chk("stall_instr", 64'(instr), 64'(word));
      chk("stall_pc", pc, exp_pc);
      chk("stall_valid", 64'(instr_valid), 64'd1);
      chk("stall_req", 64'(imem_req), 64'd0);
      step();
    end
    imem_ack    = 1'b0;
    instr_ready = 1'b1;
    if (rdy_dly > 0) chk("stall_end_instr", 64'(instr), 64'(word));
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n     = 1'b0;
    imem_ack    = 1'b0;
    imem_rdata  = 32'h0;
    instr_ready = 1'b1;
    br_taken    = 1'b0;
    uncond_br   = 1'b0;
    step();
    step();
    chk("rst_req", 64'(imem_req), 64'd0);
    chk("rst_valid", 64'(instr_valid), 64'd0);
    chk("rst_instr", 64'(instr), 64'd0);
    chk("rst_pc", pc, 64'd0);
    reset_n = 1'b1;

    // Straight-line run, then branches, stalls and wrap.
    fetch_issue(32'hAAAA_0001, 0, 0, 1'b0, 1'b0, 64'h0);
    fetch_issue(32'h1111_2222, 0, 0, 1'b0, 1'b0, 64'h4);
    fetch_issue(32'h3333_4444, 0, 0, 1'b0, 1'b0, 64'h8);
    fetch_issue(32'h5555_6666, 0, 0, 1'b0, 1'b0, 64'hC);
    fetch_issue(32'h17FF_FFFE, 0, 0, 1'b1, 1'b1, 64'h10);
    fetch_issue(32'h5400_00C0, 0, 0, 1'b1, 1'b0, 64'h8);
    fetch_issue(32'hB400_0080, 3, 0, 1'b1, 1'b0, 64'h20);
    fetch_issue(32'h17FF_FFFC, 0, 5, 1'b1, 1'b1, 64'h30);
    fetch_issue(32'hB400_0080, 0, 0, 1'b0, 1'b1, 64'h20);
    fetch_issue(32'h17FF_FFF6, 0, 0, 1'b1, 1'b1, 64'h24);
    fetch_issue(32'hD503_201F, 0, 0, 1'b0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC);

`ifdef FETCH_PERF_CNT_EN
    chk("cnt_fetch_pre", 64'(fetch_cnt), 64'd11);
    chk("cnt_taken_pre", 64'(taken_cnt), 64'd5);
`endif

    // Reset during FETCH with a late ack landing in IDLE.
    chk("wrap_addr", imem_addr, 64'h0);
    chk("wrap_req", 64'(imem_req), 64'd1);
    reset_n = 1'b0;
    step();
    chk("rst2_req", 64'(imem_req), 64'd0);
    reset_n    = 1'b1;
    imem_ack   = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    step();
    imem_ack = 1'b0;
    chk("late_ack_instr", 64'(instr), 64'd0);
    chk("late_ack_valid", 64'(instr_valid), 64'd0);
    chk("late_ack_pc", pc, 64'd0);
    chk("restart_req", 64'(imem_req), 64'd1);
`ifdef FETCH_PERF_CNT_EN
    chk("cnt_fetch_rst", 64'(fetch_cnt), 64'd0);
    chk("cnt_taken_rst", 64'(taken_cnt), 64'd0);
`endif

    fetch_issue(32'h9100_0421, 1, 0, 1'b0, 1'b0, 64'h0);
    fetch_issue(32'h8B02_0020, 0, 0, 1'b0, 1'b0, 64'h4);
    chk("final_addr", imem_addr, 64'h8);
    step();
    step();
    chk("sb_empty", 64'(sb_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
